// File: rtl/cla_add_scheduler.sv
// ---------------------------------------------------------------------------
// cla_add_scheduler
//
// Purpose: round-robin front end that shares one free-running, pipelined
// carry-lookahead adder among NUM_REQ requesters. At most one operand pair is
// accepted per cycle. A {valid, id} tag pipeline that matches the adder
// latency pairs each registered adder result with the requester that issued
// it. A drain/halt sequence lets software quiesce the adder.
//
// Ports:
//   clock, reset          rising-edge clock, synchronous active-high reset
//   req_valid/req_ready   per-requester handshake; req_ready is one-hot or zero
//   req_a/req_b           packed operands, requester i owns [i*WIDTH +: WIDTH]
//   add_a/add_b           operands to the external adder (zero when idle)
//   add_s/add_c           registered sum / carry from the external adder
//   rsp_valid/rsp_id      single-cycle result strobe and the requester index
//   rsp_sum/rsp_cout      adder sum and carry, passed straight through
//   drain_req             level request to stop issuing
//   drain_done            halted with an empty pipeline
//   busy                  at least one tag in flight
//   stat_sel/stat_count   (CLA_SCHED_STATS_EN only) read port for the
//                         per-requester 16-bit saturating grant counters
//
// Build option: define CLA_SCHED_STATS_EN to add the grant counters and
// their stat_sel/stat_count ports.
//
// state   | meaning
// --------+-----------------------------------------------------------
// RUN     | arbitration enabled, one grant per cycle
// DRAIN   | grants blocked, waiting for in-flight tags to retire
// HALTED  | grants blocked, pipeline empty, drain_done asserted
// ---------------------------------------------------------------------------
module cla_add_scheduler #(
  parameter int NUM_REQ     = 4,
  parameter int WIDTH       = 32,
  parameter int ADD_LATENCY = 2,
  parameter int ID_W        = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic [WIDTH-1:0]         add_a,
  output logic [WIDTH-1:0]         add_b,
  input  logic [WIDTH-1:0]         add_s,
  input  logic                     add_c,
  output logic                     rsp_valid,
  output logic [ID_W-1:0]          rsp_id,
  output logic [WIDTH-1:0]         rsp_sum,
  output logic                     rsp_cout,
  input  logic                     drain_req,
  output logic                     drain_done,
  output logic                     busy
`ifdef CLA_SCHED_STATS_EN
  ,
  input  logic [ID_W-1:0]          stat_sel,
  output logic [15:0]              stat_count
`endif
);

  // One extra bit so pointer + offset never overflows before the wrap fix-up.
  localparam int CAND_W = ID_W + 1;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [ID_W-1:0]         rr_ptr_q;
  logic [ADD_LATENCY-1:0]  tag_vld_q;
  logic [ID_W-1:0]         tag_id_q [ADD_LATENCY];

  logic                    grant_any;
  logic [ID_W-1:0]         winner;
  logic [CAND_W-1:0]       cand;
  logic                    handshake;
  logic [ID_W-1:0]         ptr_next;

  // -------------------------------------------------------------------------
  // Round-robin arbitration. Grants are also suppressed while reset is high
  // so nothing reaches the adder during the reset cycle itself.
  // -------------------------------------------------------------------------
  always_comb begin
    grant_any = 1'b0;
    winner    = '0;
    cand      = '0;
    if ((state_q == ST_RUN) && !reset) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        cand = {1'b0, rr_ptr_q} + CAND_W'(k);
        if (cand >= CAND_W'(NUM_REQ)) begin
          cand = cand - CAND_W'(NUM_REQ);
        end
        if (!grant_any && req_valid[cand[ID_W-1:0]]) begin
          grant_any = 1'b1;
          winner    = cand[ID_W-1:0];
        end
      end
    end
  end

  assign req_ready = grant_any ? (NUM_REQ'(1) << winner) : '0;
  assign handshake = |(req_valid & req_ready);
  assign ptr_next  = (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + ID_W'(1);

  // Idle cycles present 0+0; the tag valid of that slot stays 0.
  assign add_a = grant_any ? req_a[int'(winner)*WIDTH +: WIDTH] : '0;
  assign add_b = grant_any ? req_b[int'(winner)*WIDTH +: WIDTH] : '0;

  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr_q <= '0;
    end else if (handshake) begin
      rr_ptr_q <= ptr_next;
    end
  end

  // -------------------------------------------------------------------------
  // Tag pipeline, one stage per adder stage, never stalls.
  // -------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      tag_vld_q <= '0;
      for (int i = 0; i < ADD_LATENCY; i++) begin
        tag_id_q[i] <= '0;
      end
    end else begin
      tag_vld_q[0] <= handshake;
      tag_id_q[0]  <= winner;
      for (int i = 1; i < ADD_LATENCY; i++) begin
        tag_vld_q[i] <= tag_vld_q[i-1];
        tag_id_q[i]  <= tag_id_q[i-1];
      end
    end
  end

  assign busy      = |tag_vld_q;
  assign rsp_valid = tag_vld_q[ADD_LATENCY-1];
  assign rsp_id    = tag_id_q[ADD_LATENCY-1];
  assign rsp_sum   = add_s;
  assign rsp_cout  = add_c;

  // -------------------------------------------------------------------------
  // Drain / halt sequencing
  // -------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    drain_done = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (drain_req) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // A drain is always completed, even if drain_req drops meanwhile.
        if (!busy) begin
          state_d = ST_HALTED;
        end
      end
      ST_HALTED: begin
        drain_done = !busy;
        if (!drain_req) begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

`ifdef CLA_SCHED_STATS_EN
  // -------------------------------------------------------------------------
  // Per-requester saturating grant counters
  // -------------------------------------------------------------------------
  logic [15:0] stat_cnt_q [NUM_REQ];

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        stat_cnt_q[i] <= '0;
      end
    end else if (handshake && (stat_cnt_q[winner] != 16'hFFFF)) begin
      stat_cnt_q[winner] <= stat_cnt_q[winner] + 16'd1;
    end
  end

  assign stat_count = (int'(stat_sel) < NUM_REQ) ? stat_cnt_q[stat_sel] : '0;
`endif

endmodule

// File: tb/tb_cla_add_scheduler.sv
module tb_cla_add_scheduler;
  localparam int NUM_REQ     = 4;
  localparam int WIDTH       = 32;
  localparam int ADD_LATENCY = 2;
  localparam int ID_W        = 2;

  logic                     clock = 1'b0;
  logic                     reset;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_a;
  logic [NUM_REQ*WIDTH-1:0] req_b;
  logic [WIDTH-1:0]         add_a;
  logic [WIDTH-1:0]         add_b;
  logic [WIDTH-1:0]         add_s;
  logic                     add_c;
  logic                     rsp_valid;
  logic [ID_W-1:0]          rsp_id;
  logic [WIDTH-1:0]         rsp_sum;
  logic                     rsp_cout;
  logic                     drain_req;
  logic                     drain_done;
  logic                     busy;
`ifdef CLA_SCHED_STATS_EN
  logic [ID_W-1:0]          stat_sel;
  logic [15:0]              stat_count;
`endif

  cla_add_scheduler #(
    .NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .ADD_LATENCY(ADD_LATENCY), .ID_W(ID_W)
  ) u_dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .add_a(add_a), .add_b(add_b), .add_s(add_s), .add_c(add_c),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_cout(rsp_cout),
    .drain_req(drain_req), .drain_done(drain_done), .busy(busy)
`ifdef CLA_SCHED_STATS_EN
    , .stat_sel(stat_sel), .stat_count(stat_count)
`endif
  );

  always #5 clock = ~clock;

  // External pipelined adder: registered result ADD_LATENCY edges after inputs.
  logic [WIDTH:0] adder_pipe [ADD_LATENCY];
  always @(posedge clock) begin
    adder_pipe[0] <= {1'b0, add_a} + {1'b0, add_b};
    for (int i = 1; i < ADD_LATENCY; i++) adder_pipe[i] <= adder_pipe[i-1];
  end
  assign add_s = adder_pipe[ADD_LATENCY-1][WIDTH-1:0];
  assign add_c = adder_pipe[ADD_LATENCY-1][WIDTH];

  // Reference model state
  typedef struct {
    int             due;
    int             id;
    logic [WIDTH:0] sum;
  } rsp_t;

  rsp_t               exp_q[$];
  int                 grant_log[$];
  int                 cyc = 0;
  int                 m_ptr;
  int                 m_mode;   // 0 running, 1 draining, 2 halted
  int                 m_stat [NUM_REQ];
  int                 n_tests = 0;
  int                 n_fail  = 0;
  logic [NUM_REQ-1:0] v;
  logic [WIDTH-1:0]   op_a [NUM_REQ];
  logic [WIDTH-1:0]   op_b [NUM_REQ];
  bit                 keep_valid;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Drive current requests, compare outputs with the model, advance one cycle.
  task automatic step();
    int                 w;
    logic [NUM_REQ-1:0] exp_ready;
    logic [WIDTH-1:0]   exp_a, exp_b;
    bit                 exp_busy;
    rsp_t               e;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_a[i*WIDTH +: WIDTH] = op_a[i];
      req_b[i*WIDTH +: WIDTH] = op_b[i];
    end
    req_valid = v;
    #1;
    w = -1;
    if (m_mode == 0) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (w < 0 && v[(m_ptr + k) % NUM_REQ]) w = (m_ptr + k) % NUM_REQ;
      end
    end
    exp_ready = '0;
    exp_a     = '0;
    exp_b     = '0;
    if (w >= 0) begin
      exp_ready[w] = 1'b1;
      exp_a        = op_a[w];
      exp_b        = op_b[w];
    end
    exp_busy = (exp_q.size() != 0);
    check_val("req_ready", 64'(req_ready), 64'(exp_ready));
    check_val("add_a", 64'(add_a), 64'(exp_a));
    check_val("add_b", 64'(add_b), 64'(exp_b));
    check_val("busy", 64'(busy), 64'(exp_busy));
    check_val("drain_done", 64'(drain_done), 64'(m_mode == 2));
`ifdef CLA_SCHED_STATS_EN
    check_val("stat_count", 64'(stat_count), 64'(m_stat[stat_sel]));
`endif
    if (exp_q.size() != 0 && exp_q[0].due == cyc) begin
      e = exp_q.pop_front();
      check_val("rsp_valid", 64'(rsp_valid), 64'd1);
      check_val("rsp_id", 64'(rsp_id), 64'(e.id));
      check_val("rsp_sum", 64'(rsp_sum), 64'(e.sum[WIDTH-1:0]));
      check_val("rsp_cout", 64'(rsp_cout), 64'(e.sum[WIDTH]));
    end else begin
      check_val("rsp_valid_idle", 64'(rsp_valid), 64'd0);
    end
    if (req_ready != '0) grant_log.push_back($clog2(req_ready));
    if (w >= 0) begin
      e.due = cyc + ADD_LATENCY;
      e.id  = w;
      e.sum = {1'b0, op_a[w]} + {1'b0, op_b[w]};
      exp_q.push_back(e);
      m_ptr = (w + 1) % NUM_REQ;
      if (m_stat[w] < 16'hFFFF) m_stat[w]++;
      if (!keep_valid) v[w] = 1'b0;
    end
    case (m_mode)
      0:       if (drain_req) m_mode = 1;
      1:       if (!exp_busy) m_mode = 2;
      default: if (!drain_req) m_mode = 0;
    endcase
    @(posedge clock);
    cyc++;
    @(negedge clock);
  endtask

  task automatic do_reset(input int n);
    reset      = 1'b1;
    v          = '0;
    req_valid  = '0;
    drain_req  = 1'b0;
    keep_valid = 1'b0;
    repeat (n) begin
      @(posedge clock);
      cyc++;
    end
    @(negedge clock);
    reset = 1'b0;
    exp_q.delete();
    m_ptr  = 0;
    m_mode = 0;
    for (int i = 0; i < NUM_REQ; i++) m_stat[i] = 0;
    #1;
    check_val("rst_req_ready", 64'(req_ready), 64'd0);
    check_val("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check_val("rst_rsp_id", 64'(rsp_id), 64'd0);
    check_val("rst_busy", 64'(busy), 64'd0);
    check_val("rst_drain_done", 64'(drain_done), 64'd0);
    check_val("rst_add_a", 64'(add_a), 64'd0);
    check_val("rst_add_b", 64'(add_b), 64'd0);
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  function automatic logic [WIDTH-1:0] rand_op();
    case ($urandom_range(0, 3))
      0:       return '1;
      1:       return '0;
      default: return WIDTH'($urandom);
    endcase
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NUM_REQ; i++) begin
      op_a[i] = '0;
      op_b[i] = '0;
    end
    req_a = '0;
    req_b = '0;
`ifdef CLA_SCHED_STATS_EN
    stat_sel = '0;
`endif
    do_reset(3);

    // Single requester with carry out: FFFFFFFF + 1
    idle(2);
    op_a[2] = 32'hFFFF_FFFF;
    op_b[2] = 32'h0000_0001;
    v[2]    = 1'b1;
    idle(5);

    // Round-robin fairness with all requesters continuously valid
    do_reset(1);
    for (int i = 0; i < NUM_REQ; i++) begin
      op_a[i] = 32'h1000_0000 * (i + 1);
      op_b[i] = 32'h0000_0011 * (i + 1);
    end
    grant_log.delete();
    keep_valid = 1'b1;
    v          = '1;
    idle(8);
    keep_valid = 1'b0;
    v          = '0;
    idle(3);
    check_val("rr_count", 64'(grant_log.size()), 64'd8);
    for (int i = 0; i < 8 && i < grant_log.size(); i++)
      check_val("rr_order", 64'(grant_log[i]), 64'(i % NUM_REQ));

    // Pointer wrap: requester 3 granted, then 0 and 3 compete
    do_reset(1);
    grant_log.delete();
    v = 4'b1000;
    step();
    v = 4'b1001;
    step();
    idle(3);
    check_val("wrap_count", 64'(grant_log.size()), 64'd3);
    if (grant_log.size() >= 2) check_val("wrap_winner", 64'(grant_log[1]), 64'd0);

    // Drain raised in the cycle of the second grant, extra request blocked
    v[0] = 1'b1;
    step();
    v[1]      = 1'b1;
    drain_req = 1'b1;
    step();
    v[2] = 1'b1;
    idle(6);
    drain_req = 1'b0;
    idle(4);

    // drain_req dropped while draining
    v[0]      = 1'b1;
    drain_req = 1'b1;
    step();
    drain_req = 1'b0;
    idle(6);

    // Drain with an empty pipeline
    drain_req = 1'b1;
    idle(4);
    drain_req = 1'b0;
    idle(2);

    // Reset one cycle after a grant
    op_a[1] = 32'h8000_0000;
    op_b[1] = 32'h8000_0000;
    v[1]    = 1'b1;
    step();
    do_reset(1);
    idle(3);
    grant_log.delete();
    v = '1;
    step();
    v = '0;
    idle(3);
    if (grant_log.size() != 0) check_val("post_rst_first", 64'(grant_log[0]), 64'd0);
    else check_val("post_rst_grant", 64'd0, 64'd1);

    // Randomized traffic with occasional drains
    do_reset(2);
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!v[i] && $urandom_range(0, 2) == 0) begin
          v[i]    = 1'b1;
          op_a[i] = rand_op();
          op_b[i] = rand_op();
        end else if (v[i] && $urandom_range(0, 15) == 0) begin
          v[i] = 1'b0;
        end
      end
      if ($urandom_range(0, 39) == 0) drain_req = ~drain_req;
      step();
    end
    drain_req = 1'b0;
    v         = '0;
    idle(6);

`ifdef CLA_SCHED_STATS_EN
    // Grant counters: five grants, then saturation
    do_reset(1);
    stat_sel   = 2'd1;
    keep_valid = 1'b1;
    v          = 4'b0010;
    idle(5);
    v          = '0;
    keep_valid = 1'b0;
    idle(1);
    check_val("stat_five", 64'(stat_count), 64'd5);
    stat_sel   = 2'd0;
    keep_valid = 1'b1;
    v          = 4'b0001;
    idle(65540);
    v          = '0;
    keep_valid = 1'b0;
    idle(3);
    check_val("stat_sat", 64'(stat_count), 64'hFFFF);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cla_add_scheduler.md
Name: cla_add_scheduler

Overview:
- Round-robin scheduler that shares one pipelined 32-bit carry-lookahead adder among NUM_REQ requesters.
- Accepts at most one operand pair per cycle using per-requester valid/ready handshakes.
- Tracks each in-flight operation with a tag pipeline matched to the adder latency, and returns each sum, carry and requester id exactly ADD_LATENCY cycles after acceptance.
- Provides a drain/halt sequence so software can quiesce the adder.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- WIDTH, 32, operand/sum width; must match the adder.
- ADD_LATENCY, 2, cycles from operands at the adder inputs to a registered sum at its outputs.
- ID_W, 2, requester id width; must satisfy 2^ID_W >= NUM_REQ.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester operand valid.
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- req_a  in  NUM_REQ*WIDTH  packed operand A; requester i owns bits [i*WIDTH +: WIDTH].
- req_b  in  NUM_REQ*WIDTH  packed operand B; same packing as req_a.
- add_a  out  WIDTH  to adder a_inp.
- add_b  out  WIDTH  to adder b_inp.
- add_s  in  WIDTH  from adder s_out.
- add_c  in  1  from adder c_out.
- rsp_valid  out  1  result valid; single-cycle, no backpressure.
- rsp_id  out  ID_W  requester index of the result.
- rsp_sum  out  WIDTH  sum.
- rsp_cout  out  1  carry out.
- drain_req  in  1  level request to stop issuing.
- drain_done  out  1  high while halted with an empty pipeline.
- busy  out  1  high when any tag is in flight.

Behaviour:
- Clock is clock; reset is synchronous, active-high. All state updates on the rising edge of clock.
- Reset clears the following:
  - state goes to RUN.
  - Round-robin pointer goes to 0.
  - Tag pipeline valid bits go to 0.
  - Observable result: req_ready=0, rsp_valid=0, rsp_id=0, drain_done=0, busy=0, add_a=add_b=0.
- Reset mid-operation discards all in-flight tags. Adder outputs still emerging are ignored, because the tag valids are 0.
- Arbitration (combinational, state RUN only):
  - Search req_valid starting at the pointer index, ascending with wrap-around.
  - The first set bit wins; req_ready[winner]=1.
  - A handshake is req_valid[i] & req_ready[i].
  - On a handshake the pointer becomes winner+1 mod NUM_REQ. With no handshake the pointer holds.
- Adder drive:
  - add_a/add_b equal the winner's operands when a grant occurs.
  - Otherwise they are 0. Idle cycles therefore present 0+0 and create no tag.
- Tag pipeline:
  - ADD_LATENCY stages of {valid, id}.
  - Stage 0 loads {handshake, winner} every cycle; the stages shift every cycle.
  - There is no stall: the adder is free-running.
- Response:
  - rsp_valid = last-stage valid; rsp_id = last-stage id.
  - rsp_sum = add_s and rsp_cout = add_c, passed through combinationally.
  - A handshake in cycle t gives rsp_valid in cycle t+ADD_LATENCY.
  - rsp_sum is the modulo-2^WIDTH sum; rsp_cout is bit WIDTH of the full sum.
- Throughput: one operation per cycle. Back-to-back grants to the same requester are allowed only when it is the sole requester.
- busy = OR of all stage valids.
- State machine:
  - RUN: grants enabled. drain_req=1 moves to DRAIN on the next edge. Grants in the cycle drain_req first rises still occur.
  - DRAIN: req_ready=0. When busy=0, move to HALTED.
  - HALTED: drain_done=1 and req_ready=0. drain_req=0 moves to RUN on the next edge.
  - drain_req dropping while in DRAIN: complete the drain to HALTED, then return to RUN on the next edge.
  - drain_req asserted with an empty pipeline: RUN→DRAIN→HALTED takes 2 edges.
- Requesters must hold req_valid and operands stable until the handshake. Deasserting before the grant is legal and simply loses arbitration.

Optional Feature:
- Macro: CLA_SCHED_STATS_EN.
- Defined:
  - Adds per-requester 16-bit saturating grant counters, cleared by reset.
  - A counter increments on each handshake of its requester and saturates at 0xFFFF.
  - Adds ports stat_sel (in, ID_W) and stat_count (out, 16), where stat_count is the counter selected by stat_sel, combinational.
- Undefined: no counters and no stat ports; behaviour is otherwise identical.

Test Plan:
- Single requester, all timing with ADD_LATENCY=2:
  - Stimulus: requester 2 presents a=0xFFFFFFFF, b=0x00000001 at cycle 5.
  - Response: req_ready[2]=1 at cycle 5; rsp_valid=1, rsp_id=2, rsp_sum=0x00000000, rsp_cout=1 at cycle 7; rsp_valid=0 otherwise.
- Round-robin fairness:
  - Stimulus: all 4 requesters valid continuously for 8 cycles after reset.
  - Response: grant order 0,1,2,3,0,1,2,3; responses arrive with ids in the same order, 2 cycles later, one per cycle.
- Pointer wrap:
  - Stimulus: requester 3 is granted, then requesters 0 and 3 both request.
  - Response: requester 0 wins next.
- Drain:
  - Stimulus: 2 ops issued, drain_req raised in the cycle of the second grant.
  - Response: both responses delivered; req_ready=0 from the next cycle; drain_done=1 once busy=0; RUN resumes one edge after drain_req=0.
- Reset mid-flight:
  - Stimulus: reset asserted 1 cycle after a grant.
  - Response: no rsp_valid follows; all outputs 0; the next grant after reset starts from requester 0.
- Stats (CLA_SCHED_STATS_EN defined):
  - Stimulus: 5 grants to requester 1 with stat_sel=1.
  - Response: stat_count=5; a counter preloaded near 0xFFFF holds at 0xFFFF.
